// File: rtl/hazard_pkg.sv
// Shared encodings, latency defaults and the in-flight stage record for the
// D/E/M/W hazard and forwarding controller.
package hazard_pkg;

    localparam int RA_W_DEF    = 5;
    localparam int TN_W_DEF    = 2;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    // Tuse: cycles from D until the operand is consumed; 3 means never read.
    localparam logic [TN_W_DEF-1:0] TUSE_D    = 2'd0;
    localparam logic [TN_W_DEF-1:0] TUSE_E    = 2'd1;
    localparam logic [TN_W_DEF-1:0] TUSE_M    = 2'd2;
    localparam logic [TN_W_DEF-1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles after E entry until the result can be forwarded.
    localparam logic [TN_W_DEF-1:0] TNEW_E = 2'd0;
    localparam logic [TN_W_DEF-1:0] TNEW_M = 2'd1;
    localparam logic [TN_W_DEF-1:0] TNEW_W = 2'd2;

    typedef struct packed {
        logic [RA_W_DEF-1:0] wa;
        logic [TN_W_DEF-1:0] tnew;
        logic [RA_W_DEF-1:0] rs;
        logic [RA_W_DEF-1:0] rt;
        logic                md_start;
        logic                md_div;
    } stage_t;

    function automatic logic [TN_W_DEF-1:0] tnew_dec(input logic [TN_W_DEF-1:0] t);
        return (t == '0) ? '0 : t - TN_W_DEF'(1);
    endfunction

endpackage

// File: rtl/fwd_mux3.sv
// Priority operand bypass: first source whose address matches and whose
// result is ready wins; address 0 never forwards.
module fwd_mux3 #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic [RA_W-1:0]   addr,
    input  logic [RA_W-1:0]   wa1,
    input  logic              rdy1,
    input  logic [DATA_W-1:0] val1,
    input  logic [RA_W-1:0]   wa2,
    input  logic              rdy2,
    input  logic [DATA_W-1:0] val2,
    input  logic [RA_W-1:0]   wa3,
    input  logic              rdy3,
    input  logic [DATA_W-1:0] val3,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] out
);

    logic live;
    assign live = (addr != '0);

    always_comb begin
        out = raw;
        if (live && wa1 == addr && rdy1)
            out = val1;
        else if (live && wa2 == addr && rdy2)
            out = val2;
        else if (live && wa3 == addr && rdy3)
            out = val3;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Tnew/Tuse stall generator, mult/div busy tracker and operand bypass muxes.
// Define DFWD_FROM_W_EN to enable the W->D bypass (else regfile is write-through).
module hazard_fwd_unit import hazard_pkg::*; #(
    parameter int DATA_W  = 32,
    parameter int RA_W    = RA_W_DEF,
    parameter int TN_W    = TN_W_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RA_W-1:0]   d_rs,
    input  logic [RA_W-1:0]   d_rt,
    input  logic [TN_W-1:0]   d_tuse_rs,
    input  logic [TN_W-1:0]   d_tuse_rt,
    input  logic [RA_W-1:0]   d_wa,
    input  logic [TN_W-1:0]   d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_md_use,
    input  logic [DATA_W-1:0] d_rd1,
    input  logic [DATA_W-1:0] d_rd2,
    input  logic [DATA_W-1:0] e_rd1,
    input  logic [DATA_W-1:0] e_rd2,
    input  logic [DATA_W-1:0] m_rt_raw,
    input  logic [DATA_W-1:0] e_res,
    input  logic [DATA_W-1:0] m_res,
    input  logic [DATA_W-1:0] w_res,
    output logic              stall,
    output logic              md_busy,
    output logic [DATA_W-1:0] d_rs_fwd,
    output logic [DATA_W-1:0] d_rt_fwd,
    output logic [DATA_W-1:0] e_rs_fwd,
    output logic [DATA_W-1:0] e_rt_fwd,
    output logic [DATA_W-1:0] m_rt_fwd
);

`ifdef DFWD_FROM_W_EN
    localparam logic D_W_EN = 1'b1;
`else
    localparam logic D_W_EN = 1'b0;
`endif

    stage_t           e_st;
    logic [RA_W-1:0]  m_wa;
    logic [TN_W-1:0]  m_tnew;
    logic [RA_W-1:0]  m_rt;
    logic [RA_W-1:0]  w_wa;
    logic [CNT_W-1:0] cnt;

    logic rs_haz, rt_haz, e_rdy, m_rdy;

    assign rs_haz = (d_rs != '0) &&
                    ((e_st.wa == d_rs && e_st.tnew > d_tuse_rs) ||
                     (m_wa == d_rs && m_tnew > d_tuse_rs));
    assign rt_haz = (d_rt != '0) &&
                    ((e_st.wa == d_rt && e_st.tnew > d_tuse_rt) ||
                     (m_wa == d_rt && m_tnew > d_tuse_rt));

    assign md_busy = e_st.md_start || (cnt != '0);
    assign stall   = rs_haz || rt_haz || (d_md_use && md_busy);
    assign e_rdy   = (e_st.tnew == '0);
    assign m_rdy   = (m_tnew == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            e_st   <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
            m_rt   <= '0;
            w_wa   <= '0;
            cnt    <= '0;
        end else begin
            // A stalled D inserts a bubble so the frozen instruction is not issued twice.
            if (stall)
                e_st <= '0;
            else
                e_st <= '{wa: d_wa, tnew: d_tnew, rs: d_rs, rt: d_rt,
                          md_start: d_md_start, md_div: d_md_div};
            m_wa   <= e_st.wa;
            m_tnew <= tnew_dec(e_st.tnew);
            m_rt   <= e_st.rt;
            w_wa   <= m_wa;
            if (e_st.md_start)
                cnt <= e_st.md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

    fwd_mux3 #(.DATA_W(DATA_W), .RA_W(RA_W)) u_d_rs (
        .addr(d_rs), .wa1(e_st.wa), .rdy1(e_rdy), .val1(e_res),
        .wa2(m_wa), .rdy2(m_rdy), .val2(m_res),
        .wa3(w_wa), .rdy3(D_W_EN), .val3(w_res),
        .raw(d_rd1), .out(d_rs_fwd)
    );

    fwd_mux3 #(.DATA_W(DATA_W), .RA_W(RA_W)) u_d_rt (
        .addr(d_rt), .wa1(e_st.wa), .rdy1(e_rdy), .val1(e_res),
        .wa2(m_wa), .rdy2(m_rdy), .val2(m_res),
        .wa3(w_wa), .rdy3(D_W_EN), .val3(w_res),
        .raw(d_rd2), .out(d_rt_fwd)
    );

    // E and M consumers only ever see older producers; the third slot is idle.
    fwd_mux3 #(.DATA_W(DATA_W), .RA_W(RA_W)) u_e_rs (
        .addr(e_st.rs), .wa1(m_wa), .rdy1(m_rdy), .val1(m_res),
        .wa2(w_wa), .rdy2(1'b1), .val2(w_res),
        .wa3('0), .rdy3(1'b0), .val3('0),
        .raw(e_rd1), .out(e_rs_fwd)
    );

    fwd_mux3 #(.DATA_W(DATA_W), .RA_W(RA_W)) u_e_rt (
        .addr(e_st.rt), .wa1(m_wa), .rdy1(m_rdy), .val1(m_res),
        .wa2(w_wa), .rdy2(1'b1), .val2(w_res),
        .wa3('0), .rdy3(1'b0), .val3('0),
        .raw(e_rd2), .out(e_rt_fwd)
    );

    fwd_mux3 #(.DATA_W(DATA_W), .RA_W(RA_W)) u_m_rt (
        .addr(m_rt), .wa1(w_wa), .rdy1(1'b1), .val1(w_res),
        .wa2('0), .rdy2(1'b0), .val2('0),
        .wa3('0), .rdy3(1'b0), .val3('0),
        .raw(m_rt_raw), .out(m_rt_fwd)
    );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: stalls, bypass priority, mult/div busy
// window and mid-flight reset, with hand-computed expectations.
module tb_hazard_fwd_unit;

    localparam logic [31:0] RAW_D1 = 32'hD100_0001;
    localparam logic [31:0] RAW_D2 = 32'hD200_0002;
    localparam logic [31:0] RAW_E1 = 32'hE100_0003;
    localparam logic [31:0] RAW_E2 = 32'hE200_0004;
    localparam logic [31:0] RAW_MT = 32'hC0DE_0005;
    localparam logic [31:0] DEF_ER = 32'hAAAA_0006;
    localparam logic [31:0] DEF_MR = 32'hBBBB_0007;
    localparam logic [31:0] DEF_WR = 32'hCCCC_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, d_wa;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_md_start, d_md_div, d_md_use;
    logic [31:0] d_rd1, d_rd2, e_rd1, e_rd2, m_rt_raw, e_res, m_res, w_res;
    logic        stall, md_busy;
    logic [31:0] d_rs_fwd, d_rt_fwd, e_rs_fwd, e_rt_fwd, m_rt_fwd;

    int errors = 0;
    int checks = 0;

    hazard_fwd_unit dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wa(d_wa), .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .d_rd1(d_rd1), .d_rd2(d_rd2), .e_rd1(e_rd1), .e_rd2(e_rd2),
        .m_rt_raw(m_rt_raw), .e_res(e_res), .m_res(m_res), .w_res(w_res),
        .stall(stall), .md_busy(md_busy), .d_rs_fwd(d_rs_fwd), .d_rt_fwd(d_rt_fwd),
        .e_rs_fwd(e_rs_fwd), .e_rt_fwd(e_rt_fwd), .m_rt_fwd(m_rt_fwd)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] wa, input logic [1:0] tn,
                         input logic ms, input logic mdv, input logic mu);
        d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
        d_wa = wa; d_tnew = tn; d_md_start = ms; d_md_div = mdv; d_md_use = mu;
    endtask

    task automatic set_idle();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_raw_defaults();
        d_rd1 = RAW_D1; d_rd2 = RAW_D2; e_rd1 = RAW_E1; e_rd2 = RAW_E2;
        m_rt_raw = RAW_MT; e_res = DEF_ER; m_res = DEF_MR; w_res = DEF_WR;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_raw_defaults();
        reset = 1'b1;
        set_d(5'd1, 5'd2, 2'd0, 2'd0, 5'd3, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%0b exp=0", stall);
        if (stall !== 1'b0) errors++;
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got=%0b exp=0", md_busy); end
        checks++; if (d_rs_fwd !== RAW_D1) begin errors++; $display("FAIL reset_d_rs got=%h exp=%h", d_rs_fwd, RAW_D1); end
        checks++; if (d_rt_fwd !== RAW_D2) begin errors++; $display("FAIL reset_d_rt got=%h exp=%h", d_rt_fwd, RAW_D2); end
        checks++; if (e_rs_fwd !== RAW_E1) begin errors++; $display("FAIL reset_e_rs got=%h exp=%h", e_rs_fwd, RAW_E1); end
        checks++; if (e_rt_fwd !== RAW_E2) begin errors++; $display("FAIL reset_e_rt got=%h exp=%h", e_rt_fwd, RAW_E2); end
        checks++; if (m_rt_fwd !== RAW_MT) begin errors++; $display("FAIL reset_m_rt got=%h exp=%h", m_rt_fwd, RAW_MT); end
        set_idle();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load_use();
        logic [31:0] exp_w;
        set_raw_defaults();
        w_res = 32'h0000_1234;
        // lw $1 (result available at W) followed by beq using $1 in D
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall_c1 got=%0b exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lw_stall_c2 got=%0b exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lw_stall_c3 got=%0b exp=0", stall); end
`ifdef DFWD_FROM_W_EN
        exp_w = 32'h0000_1234;
`else
        exp_w = RAW_D1;
`endif
        checks++; if (d_rs_fwd !== exp_w) begin errors++; $display("FAIL lw_d_rs got=%h exp=%h", d_rs_fwd, exp_w); end
        // ALU $3 (tnew=1) then beq on $3: one stall, then bypass from M
        m_res = 32'h0000_1234;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL alu_stall got=%0b exp=1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall_drop got=%0b exp=0", stall); end
        checks++; if (d_rs_fwd !== 32'h0000_1234) begin errors++; $display("FAIL alu_d_rs_from_m got=%h exp=00001234", d_rs_fwd); end
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_e_fwd_from_m();
        set_raw_defaults();
        m_res = 32'hA5A5_A5A5;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd2, 2'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL addu_tuse1_nostall got=%0b exp=0", stall); end
        tick();
        checks++; if (e_rt_fwd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL e_rt_from_m got=%h exp=a5a5a5a5", e_rt_fwd); end
        // writer to $0 must never forward
        m_res = 32'hFFFF_FFFF;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (e_rt_fwd !== RAW_E2) begin errors++; $display("FAIL zero_reg_no_fwd got=%h exp=%h", e_rt_fwd, RAW_E2); end
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_jal_jr();
        set_raw_defaults();
        e_res = 32'h0000_3008;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL jr_nostall got=%0b exp=0", stall); end
        checks++; if (d_rs_fwd !== 32'h0000_3008) begin errors++; $display("FAIL jr_d_rs_from_e got=%h exp=00003008", d_rs_fwd); end
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_md_busy(input logic is_div, input int exp_cycles);
        int  busy_cnt;
        bit  done;
        busy_cnt = 0;
        done = 1'b0;
        set_raw_defaults();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, is_div, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (md_busy) begin
                busy_cnt++;
                checks++;
                if (stall !== 1'b1) begin errors++; $display("FAIL md_stall cyc=%0d got=%0b exp=1", i, stall); end
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                checks++;
                if (stall !== 1'b0) begin errors++; $display("FAIL md_stall_drop got=%0b exp=0", stall); end
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL md_timeout busy after 20 cycles"); end
        checks++; if (busy_cnt !== exp_cycles) begin errors++; $display("FAIL md_busy_len div=%0b got=%0d exp=%0d", is_div, busy_cnt, exp_cycles); end
        set_idle();
        tick();
    endtask

    task automatic test_m_over_w();
        set_raw_defaults();
        m_res = 32'd1;
        w_res = 32'd2;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mw_nostall got=%0b exp=0", stall); end
        tick();
        checks++; if (e_rs_fwd !== 32'd1) begin errors++; $display("FAIL e_rs_m_over_w got=%h exp=00000001", e_rs_fwd); end
        // sw in M with rt=$5 while W writes $5
        set_raw_defaults();
        w_res = 32'd7;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd5, 2'd3, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sw_nostall got=%0b exp=0", stall); end
        tick();
        set_idle();
        tick();
        checks++; if (m_rt_fwd !== 32'd7) begin errors++; $display("FAIL m_rt_from_w got=%h exp=00000007", m_rt_fwd); end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        set_raw_defaults();
        e_res = 32'h0000_0E0E;
        m_res = 32'h0000_0D0D;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd6, 5'd6, 2'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_nostall got=%0b exp=0", stall); end
        checks++; if (d_rs_fwd !== 32'h0000_0E0E) begin errors++; $display("FAIL b2b_d_rs_e_over_m got=%h exp=00000e0e", d_rs_fwd); end
        checks++; if (d_rt_fwd !== 32'h0000_0E0E) begin errors++; $display("FAIL b2b_d_rt_e_over_m got=%h exp=00000e0e", d_rt_fwd); end
        set_idle();
        tick();
        tick();
    endtask

    task automatic test_reset_midflight();
        logic [31:0] exp_w;
        set_raw_defaults();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        tick();
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        set_d(5'd1, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got=%0b exp=1", stall); end
        checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL pre_reset_busy got=%0b exp=1", md_busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got=%0b exp=0", stall); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%0b exp=0", md_busy); end
        checks++; if (d_rs_fwd !== RAW_D1) begin errors++; $display("FAIL post_reset_d_rs got=%h exp=%h", d_rs_fwd, RAW_D1); end
        // W-only match in D
        w_res = 32'h0000_4444;
        set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0);
        tick();
        set_idle();
        tick();
        tick();
        set_d(5'd4, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef DFWD_FROM_W_EN
        exp_w = 32'h0000_4444;
`else
        exp_w = RAW_D1;
`endif
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL w_only_nostall got=%0b exp=0", stall); end
        checks++; if (d_rs_fwd !== exp_w) begin errors++; $display("FAIL w_only_d_rs got=%h exp=%h", d_rs_fwd, exp_w); end
        set_idle();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_idle();
        set_raw_defaults();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_e_fwd_from_m();
        test_jal_jr();
        test_md_busy(1'b1, 11);
        test_md_busy(1'b0, 6);
        test_m_over_w();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
